// File: rtl/thermo_pkg.sv
// Shared types for the thermometer-code decoder.
// With THERMO_BUBBLE_CHECK_EN defined, each buffer entry also carries an err_bubble bit.
package thermo_pkg;

   localparam int FRAME_LEN_DEF = 256;

   typedef enum logic {IDLE, COLLECT} state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       err_zero;
`ifdef THERMO_BUBBLE_CHECK_EN
      logic       err_bubble;
`endif
   } entry_t;

endpackage

// File: rtl/thermo_decode_if.sv
// Comparator-stream input and recovered-sample output bundle of thermo_decode.
interface thermo_decode_if;
   logic       in_bit;
   logic       in_valid;
   logic       frame_sync;
   logic [7:0] data_out;
   logic       out_valid;
   logic       out_ready;
   logic       err_zero;
   logic       err_bubble;
   logic       overflow;

   modport master (
      output in_bit, in_valid, frame_sync, out_ready,
      input  data_out, out_valid, err_zero, err_bubble, overflow
   );

   modport slave (
      input  in_bit, in_valid, frame_sync, out_ready,
      output data_out, out_valid, err_zero, err_bubble, overflow
   );
endinterface

// File: rtl/thermo_out_fifo.sv
// Two-entry registered result FIFO.
// A push that finds the FIFO full with no pop in the same cycle is dropped, and a sticky flag records the loss.
module thermo_out_fifo
   import thermo_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   empty_o,
   output logic   overflow_o
);
   entry_t     mem_q [2];
   logic       wr_ptr_q, rd_ptr_q, ovf_q;
   logic [1:0] cnt_q, cnt_d;
   logic       full, do_push, do_pop;

   assign full       = (cnt_q == 2'd2);
   assign empty_o    = (cnt_q == 2'd0);
   assign do_pop     = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push    = push_i && (!full || do_pop);
   assign cnt_d      = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
   assign head_o     = mem_q[rd_ptr_q];
   assign overflow_o = ovf_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         if (push_i && !do_push) ovf_q <= 1'b1;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/thermo_decode.sv
// Counts the ones in each comparator frame to recover the 8-bit sample, then queues it for the consumer.
// With THERMO_BUBBLE_CHECK_EN defined, the decoder also flags any 0->1 transition inside a frame.
module thermo_decode
   import thermo_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CNT_W     = $clog2(FRAME_LEN) + 1
) (
   input logic            CLK100MHZ,
   input logic            reset,
   thermo_decode_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   state_e           state_q;
   logic [CNT_W-1:0] bit_idx_q, ones_q, ones_d;
   logic             restart, done, pop, empty;
   entry_t           ent_d, head;

`ifdef THERMO_BUBBLE_CHECK_EN
   logic prev_q, bubble_q, bubble_d;
   assign bubble_d = bubble_q | (~prev_q & bus.in_bit);
`endif

   // A sync bit always starts a new frame, even if a partial frame is still in progress.
   assign restart = bus.in_valid && bus.frame_sync;
   assign done    = bus.in_valid && !bus.frame_sync && (state_q == COLLECT) && (bit_idx_q == LAST);

   always_comb begin
      ones_d         = ones_q + CNT_W'(bus.in_bit);
      ent_d          = '0;
      ent_d.err_zero = (ones_d == '0);
      ent_d.data     = ent_d.err_zero ? 8'd0 : 8'(ones_d - CNT_W'(1));
`ifdef THERMO_BUBBLE_CHECK_EN
      ent_d.err_bubble = bubble_d;
`endif
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         ones_q    <= '0;
`ifdef THERMO_BUBBLE_CHECK_EN
         prev_q    <= 1'b0;
         bubble_q  <= 1'b0;
`endif
      end else if (restart) begin
         state_q   <= COLLECT;
         bit_idx_q <= CNT_W'(1);
         ones_q    <= CNT_W'(bus.in_bit);
`ifdef THERMO_BUBBLE_CHECK_EN
         prev_q    <= bus.in_bit;
         bubble_q  <= 1'b0;
`endif
      end else if (bus.in_valid && state_q == COLLECT) begin
         bit_idx_q <= bit_idx_q + CNT_W'(1);
         ones_q    <= ones_d;
         if (done) state_q <= IDLE;
`ifdef THERMO_BUBBLE_CHECK_EN
         prev_q    <= bus.in_bit;
         bubble_q  <= bubble_d;
`endif
      end
   end

   thermo_out_fifo u_fifo (
      .clk_i       (CLK100MHZ),
      .rst_i       (reset),
      .push_i      (done),
      .push_data_i (ent_d),
      .pop_i       (pop),
      .head_o      (head),
      .empty_o     (empty),
      .overflow_o  (bus.overflow)
   );

   assign pop           = bus.out_ready && !empty;
   assign bus.out_valid = !empty;
   assign bus.data_out  = empty ? 8'd0 : head.data;
   assign bus.err_zero  = !empty && head.err_zero;
`ifdef THERMO_BUBBLE_CHECK_EN
   assign bus.err_bubble = !empty && head.err_bubble;
`else
   assign bus.err_bubble = 1'b0;
`endif
endmodule

// File: tb/tb_thermo_decode.sv
// Randomized self-checking bench for thermo_decode, using a frame-level reference model and a two-deep buffer model.
module tb_thermo_decode;
   typedef struct packed {
      logic [7:0] d;
      logic       ez;
      logic       eb;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passed = 0;
   exp_t exp_q[$];
   logic exp_ovf = 1'b0;
   logic last_vld;
   logic [10:0] last_head;

   thermo_decode_if bus ();

   thermo_decode dut (
      .CLK100MHZ (clk),
      .reset     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Reference: the sample is the count of ones minus one; a bubble is any 0 followed by a 1.
   function automatic exp_t ref_entry(input logic [255:0] b);
      exp_t e;
      int   n = $countones(b);
      e.ez = (n == 0);
      e.d  = (n == 0) ? 8'd0 : 8'(n - 1);
      e.eb = 1'b0;
`ifdef THERMO_BUBBLE_CHECK_EN
      for (int i = 1; i < 256; i++)
         if (!b[i-1] && b[i]) e.eb = 1'b1;
`endif
      return e;
   endfunction

   task automatic ref_push(input logic [255:0] b);
      if (exp_q.size() == 2) exp_ovf = 1'b1;
      else exp_q.push_back(ref_entry(b));
   endtask

   function automatic logic [255:0] thermo(input int s);
      logic [255:0] b;
      for (int i = 0; i < 256; i++) b[i] = (i <= s);
      return b;
   endfunction

   // Drives n bits with frame_sync on bit 0. Records what the head looked like while the last bit was being driven.
   task automatic send_frame(input logic [255:0] b, input int n, input int gap_pct,
                             input bit idle_after, input bit ready_on_last);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && $urandom_range(99) < gap_pct)
            repeat ($urandom_range(3, 1)) begin
               bus.in_valid   = 1'b0;
               bus.in_bit     = 1'($urandom);
               bus.frame_sync = 1'($urandom);
               @(negedge clk);
            end
         bus.in_valid   = 1'b1;
         bus.in_bit     = b[i];
         bus.frame_sync = (i == 0);
         if (i == n - 1) begin
            last_vld  = bus.out_valid;
            last_head = {bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble};
            if (ready_on_last) bus.out_ready = 1'b1;
         end
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      if (idle_after) begin
         bus.in_valid   = 1'b0;
         bus.frame_sync = 1'b0;
      end
   endtask

   task automatic pop_one(output logic [10:0] obs);
      obs = {bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble};
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.frame_sync = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble, bus.overflow} !== 12'h0)
         $display("FAIL reset_outputs: got %h want 000",
                  {bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble, bus.overflow});
      else passed++;
   endtask

   task automatic test_sample100();
      logic [10:0] obs;
      send_frame(thermo(100), 256, 0, 1, 0);
      ref_push(thermo(100));
      checks++;
      if (last_vld !== 1'b0) $display("FAIL s100_early: out_valid got %b want 0", last_vld); else passed++;
      checks++;
      if ({bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble} !== {1'b1, exp_q[0]})
         $display("FAIL s100_latency: got %h want %h",
                  {bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble}, {1'b1, exp_q[0]});
      else passed++;
      checks++;
      if (bus.data_out !== 8'd100) $display("FAIL s100_value: got %0d want 100", bus.data_out); else passed++;
      while (exp_q.size() > 0) begin
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL s100_pop: got %h want %h", obs, {1'b1, exp_q[0]});
         else passed++;
         void'(exp_q.pop_front());
      end
      checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL s100_empty: out_valid got %b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [10:0] obs;
      send_frame({256{1'b1}}, 256, 0, 0, 0);
      send_frame(256'd0, 256, 0, 1, 0);
      ref_push({256{1'b1}});
      ref_push(256'd0);
      checks++;
      if (bus.data_out !== 8'd255) $display("FAIL all_ones: got %0d want 255", bus.data_out); else passed++;
      while (exp_q.size() > 0) begin
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL b2b_pop: got %h want %h", obs, {1'b1, exp_q[0]});
         else passed++;
         if (exp_q[0].ez) begin
            checks++;
            if (obs[1] !== 1'b1 || obs[9:2] !== 8'd0)
               $display("FAIL all_zeros: got %h want err_zero=1 data=0", obs);
            else passed++;
         end
         void'(exp_q.pop_front());
      end
      checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty: out_valid got %b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_bubble();
      logic [10:0]  obs;
      logic [255:0] b = 256'b1011;
      send_frame(b, 256, 0, 1, 0);
      ref_push(b);
      checks++;
      if (bus.data_out !== 8'd2) $display("FAIL bubble_value: got %0d want 2", bus.data_out); else passed++;
      pop_one(obs); checks++;
      if (obs !== {1'b1, exp_q[0]}) $display("FAIL bubble_flag: got %h want %h", obs, {1'b1, exp_q[0]});
      else passed++;
      void'(exp_q.pop_front());
   endtask

   task automatic test_full_push_pop();
      logic [10:0] obs;
      send_frame(thermo(3), 256, 0, 1, 0); ref_push(thermo(3));
      send_frame(thermo(4), 256, 0, 1, 0); ref_push(thermo(4));
      send_frame(thermo(5), 256, 0, 1, 1);
      checks++;
      if (last_head !== {1'b1, exp_q[0]}) $display("FAIL fpp_head: got %h want %h", last_head, {1'b1, exp_q[0]});
      else passed++;
      void'(exp_q.pop_front());
      ref_push(thermo(5));
      checks++;
      if (bus.overflow !== exp_ovf) $display("FAIL fpp_overflow: got %b want %b", bus.overflow, exp_ovf); else passed++;
      while (exp_q.size() > 0) begin
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL fpp_pop: got %h want %h", obs, {1'b1, exp_q[0]});
         else passed++;
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_overflow();
      logic [10:0] obs;
      send_frame(thermo(10), 256, 0, 1, 0); ref_push(thermo(10));
      send_frame(thermo(20), 256, 0, 1, 0); ref_push(thermo(20));
      send_frame(thermo(30), 256, 0, 1, 0); ref_push(thermo(30));
      checks++;
      if (bus.overflow !== 1'b1 || bus.overflow !== exp_ovf)
         $display("FAIL ovf_set: got %b want %b", bus.overflow, exp_ovf);
      else passed++;
      while (exp_q.size() > 0) begin
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL ovf_pop: got %h want %h", obs, {1'b1, exp_q[0]});
         else passed++;
         void'(exp_q.pop_front());
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1)
         $display("FAIL ovf_sticky: valid/ovf got %b%b want 01", bus.out_valid, bus.overflow);
      else passed++;
   endtask

   task automatic test_gaps_random();
      logic [10:0]  obs;
      logic [255:0] b;
      send_frame(thermo(77), 256, 30, 1, 0);
      ref_push(thermo(77));
      checks++;
      if (bus.data_out !== 8'd77) $display("FAIL gap77: got %0d want 77", bus.data_out); else passed++;
      pop_one(obs); void'(exp_q.pop_front());
      for (int k = 0; k < 5; k++) begin
         for (int w = 0; w < 8; w++) b[w*32 +: 32] = $urandom;
         if (k == 0) b = thermo($urandom_range(255));
         if (k == 1) b = b & {8{32'h0000_0011}};
         send_frame(b, 256, 20, 1, 0);
         ref_push(b);
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL rand_frame%0d: got %h want %h", k, obs, {1'b1, exp_q[0]});
         else passed++;
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_resync();
      logic [10:0] obs;
      logic [255:0] junk = {8{32'hA5C3_5A3C}};
      send_frame(junk, 50, 10, 0, 0);
      send_frame(thermo(5), 256, 0, 1, 0);
      ref_push(thermo(5));
      checks++;
      if (bus.data_out !== 8'd5) $display("FAIL resync_value: got %0d want 5", bus.data_out); else passed++;
      while (exp_q.size() > 0) begin
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL resync_pop: got %h want %h", obs, {1'b1, exp_q[0]});
         else passed++;
         void'(exp_q.pop_front());
      end
      checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL resync_single: out_valid got %b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [10:0] obs;
      send_frame(thermo(9), 256, 0, 1, 0); ref_push(thermo(9));
      send_frame(thermo(200), 128, 0, 0, 0);
      rst = 1'b1; bus.in_valid = 1'b0; bus.frame_sync = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
      checks++;
      if ({bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble, bus.overflow} !== 12'h0)
         $display("FAIL midreset_outputs: got %h want 000",
                  {bus.out_valid, bus.data_out, bus.err_zero, bus.err_bubble, bus.overflow});
      else passed++;
      send_frame(thermo(42), 256, 0, 1, 0);
      ref_push(thermo(42));
      checks++;
      if (bus.data_out !== 8'd42 || bus.out_valid !== 1'b1)
         $display("FAIL midreset_next: got %b/%0d want 1/42", bus.out_valid, bus.data_out);
      else passed++;
      while (exp_q.size() > 0) begin
         pop_one(obs); checks++;
         if (obs !== {1'b1, exp_q[0]}) $display("FAIL midreset_pop: got %h want %h", obs, {1'b1, exp_q[0]});
         else passed++;
         void'(exp_q.pop_front());
      end
      checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL midreset_empty: out_valid got %b want 0", bus.out_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_sample100();
      test_back_to_back();
      test_bubble();
      test_full_push_pop();
      test_overflow();
      test_gaps_random();
      test_resync();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/thermo_decode.md
# thermo_decode

Downstream of the threshold encoder. Consumes the 1-bit comparator stream produced while the encoder's `delay` sweeps 0..FRAME_LEN-1 and counts the ones in each frame to recover the original 8-bit sample. Recovered values are queued in a 2-entry output buffer and delivered over a valid/ready handshake to the capture/UART logic. Malformed thermometer codes are flagged.

## Interface
- FRAME_LEN, 256: bits per frame (power of two, 2..256); equals the encoder's delay sweep length.
- CNT_W, 9: ones-counter width, $clog2(FRAME_LEN)+1.
- CLK100MHZ  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_bit  in  1  encoder `out`.
- in_valid  in  1  in_bit qualifier; the encoder's `start`, delayed one cycle to align with its registered output.
- frame_sync  in  1  marks the first bit of a frame; only meaningful when in_valid=1.
- data_out  out  8  recovered sample, head of buffer.
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer accepts.
- err_zero  out  1  head entry came from a frame with zero ones.
- err_bubble  out  1  head entry contained a 0->1 transition (macro-gated).
- overflow  out  1  sticky; a completed frame was dropped because the buffer was full.

## Operation
- One clock, CLK100MHZ. Reset is synchronous and active-high; all outputs, counters, buffer pointers and state clear to 0.
- FSM states: IDLE, COLLECT.
  - IDLE: in_valid=1 with frame_sync=1 -> COLLECT; bit_idx=1, ones=in_bit, prev=in_bit, bubble=0. in_valid=1 with frame_sync=0 -> bit ignored.
  - COLLECT: each in_valid=1 increments bit_idx and adds in_bit to ones; prev<=in_bit. in_valid=0 holds all state (gaps allowed, unbounded).
  - When bit_idx reaches FRAME_LEN-1 and in_valid=1, the frame completes: the entry is pushed and the FSM returns to IDLE.
  - frame_sync=1 with in_valid=1 while in COLLECT: the partial frame is discarded silently and a new frame starts with that bit.
- Result: ones in 1..FRAME_LEN -> data_out = ones-1, truncated to 8 bits, err_zero=0. ones=0 -> data_out=0, err_zero=1.
- Bubble: prev=0 and in_bit=1 within a frame sets bubble. It is stored with the entry.
- Buffer: 2 entries of {data[7:0], err_zero, err_bubble}. Pop on out_valid & out_ready.
  - Push when full and no pop in the same cycle: drop the entry and set overflow, which stays set until reset.
  - Push and pop in the same cycle when full: both succeed.
  - Push when empty: visible next cycle.
- err_* outputs describe the head entry only and are 0 when out_valid=0.
- Reset mid-frame: the partial frame and buffered entries are lost. No output is produced for them.

## Timing
- Latency: last frame bit sampled on edge N -> out_valid=1 and data_out valid after edge N (observable in cycle N+1).
- out_valid, data_out and err_* are registered with no combinational path from out_ready. in_* have no ready signal because the encoder cannot stall; loss is reported only via overflow.
- Throughput: one frame per FRAME_LEN valid bits. Back-to-back frames need no idle cycle: frame_sync may accompany the bit immediately after the completing bit.

## Configuration
- THERMO_BUBBLE_CHECK_EN defined: bubble tracking logic is present and err_bubble reports as above.
- THERMO_BUBBLE_CHECK_EN undefined: no prev/bubble logic. err_bubble is tied to 0 and the buffer width drops by one bit.

## Structure
- Package thermo_pkg holds:
  - FRAME_LEN default.
  - State enum {IDLE, COLLECT}.
  - Buffer entry typedef {data, err_zero, err_bubble}.
- Sub-module thermo_out_fifo: 2-entry registered FIFO with push/full/pop/empty and drop-on-full.
- thermo_decode contains the FSM, the counters and the result formatter.

## Test plan
- Sample 100, FRAME_LEN=256, ones on bits 0..100 -> data_out=100, err_zero=0, err_bubble=0, out_valid one cycle after the last bit.
- All 256 bits = 1 -> data_out=255. All bits = 0 -> data_out=0, err_zero=1.
- Pattern 1,1,0,1 then 252 zeros -> data_out=2, err_bubble=1 with the macro defined, 0 without it.
- out_ready=0, three complete frames (samples 10, 20, 30) -> 10 and 20 buffered, 30 dropped, overflow=1. Then out_ready=1 -> 10 then 20, then out_valid=0.
- Random in_valid gaps inside a frame of sample 77 -> data_out=77.
- frame_sync asserted again at bit 50 with sample 5 following -> only 5 is output.
- reset at bit 128 -> outputs 0, no entry emitted; the next full frame of sample 42 -> 42.
